// File: rtl/audio_frame_ctrl.sv
// audio_frame_ctrl: frame scheduler for the audio engine.
// On each accepted frame tick the mic samples are snapshotted and written to the
// audio-input RAM one channel per cycle at {chan, frame}. The sequencer is then
// held in reset for RESET_CYCLES cycles, released, and the block waits for done.
// In host mode the RAM write port and the frame index are handed to the host
// through a combinational mux.
module audio_frame_ctrl #(
    parameter  int CHANNELS     = 8,
    parameter  int FRAMES       = 64,
    parameter  int RESET_CYCLES = 3,
    localparam int CHAN_W       = $clog2(CHANNELS),
    localparam int FRAME_W      = $clog2(FRAMES),
    localparam int AUDIO_W      = CHAN_W + FRAME_W
) (
    input  logic                  i_ck,
    input  logic                  i_rst,
    input  logic                  i_frame_tick,
    input  logic [16*CHANNELS-1:0] i_mic_data,
    input  logic                  i_host_mode,
    input  logic [FRAME_W-1:0]    i_host_frame,
    input  logic                  i_host_we,
    input  logic [AUDIO_W-1:0]    i_host_waddr,
    input  logic [15:0]           i_host_wdata,
    input  logic                  i_host_kick,
    input  logic                  i_engine_done,
    input  logic                  i_clr_overrun,
    output logic                  o_ram_we,
    output logic [AUDIO_W-1:0]    o_ram_waddr,
    output logic [15:0]           o_ram_wdata,
    output logic [FRAME_W-1:0]    o_frame,
    output logic                  o_engine_rst_n,
    output logic                  o_busy,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        KICK  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                      r_state;
    logic [FRAME_W-1:0]          r_frame_cnt;
    logic [CHAN_W-1:0]           r_chan;
    logic [CHANNELS-1:0][15:0]   r_snap;
    logic [3:0]                  r_kcnt;
    logic                        r_eng_rst_n;
    logic                        r_busy;
    logic                        r_overrun;

    logic                        w_cap_tick;
    logic                        w_tick_late;
    logic                        w_last_chan;
    logic                        w_last_kick;

    // Ticks only count in capture mode; any tick seen outside IDLE is late.
    assign w_cap_tick  = i_frame_tick && !i_host_mode;
    assign w_tick_late = w_cap_tick && (r_state != IDLE);
    assign w_last_chan = (r_chan == CHAN_W'(CHANNELS - 1));
    assign w_last_kick = (r_kcnt == 4'(RESET_CYCLES - 1));

    // Frame sequencing FSM with registered engine reset, busy and overrun.
    always_ff @(posedge i_ck or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            r_chan      <= '0;
            r_snap      <= '0;
            r_kcnt      <= '0;
            r_eng_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Set has priority over clear so a late tick is never lost.
            if (w_tick_late)
                r_overrun <= 1'b1;
            else if (i_clr_overrun)
                r_overrun <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_cap_tick) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_snap      <= i_mic_data;
                        r_chan      <= '0;
                        r_state     <= WRITE;
                        r_busy      <= 1'b1;
                    end else if (i_host_mode && i_host_kick) begin
                        r_kcnt      <= '0;
                        r_eng_rst_n <= 1'b0;
                        r_state     <= KICK;
                        r_busy      <= 1'b1;
                    end
                end
                WRITE: begin
                    // Host takeover aborts the capture; the frame is left partial.
                    if (i_host_mode) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_chan <= r_chan + 1'b1;
                        if (w_last_chan) begin
                            r_kcnt      <= '0;
                            r_eng_rst_n <= 1'b0;
                            r_state     <= KICK;
                        end
                    end
                end
                KICK: begin
                    if (w_last_kick) begin
                        r_eng_rst_n <= 1'b1;
                        r_state     <= RUN;
                    end else begin
                        r_kcnt <= r_kcnt + 1'b1;
                    end
                end
                RUN: begin
                    // A real-time tick abandons the current engine run.
                    if (w_cap_tick) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_snap      <= i_mic_data;
                        r_chan      <= '0;
                        r_state     <= WRITE;
                    end else if (i_engine_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM port and frame index: host path is a same-cycle mux.
    always_comb begin
        if (i_host_mode) begin
            o_ram_we    = i_host_we;
            o_ram_waddr = i_host_waddr;
            o_ram_wdata = i_host_wdata;
            o_frame     = i_host_frame;
        end else begin
            o_ram_we    = (r_state == WRITE);
            o_ram_waddr = {r_chan, r_frame_cnt};
            o_ram_wdata = r_snap[r_chan];
            o_frame     = r_frame_cnt;
        end
    end

    assign o_engine_rst_n = r_eng_rst_n;
    assign o_busy         = r_busy;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_audio_frame_ctrl.sv
// Directed bench for audio_frame_ctrl: capture writes, kick timing, overrun,
// frame wrap, host-mode mux, host takeover and async reset.
module tb_audio_frame_ctrl;
    localparam int CH = 8;
    localparam int FR = 64;
    localparam int RC = 3;

    logic           ck = 1'b0;
    logic           rst = 1'b0;
    logic           frame_tick = 1'b0;
    logic [16*CH-1:0] mic = '0;
    logic           host_mode = 1'b0;
    logic [5:0]     host_frame = '0;
    logic           host_we = 1'b0;
    logic [8:0]     host_waddr = '0;
    logic [15:0]    host_wdata = '0;
    logic           host_kick = 1'b0;
    logic           engine_done = 1'b0;
    logic           clr_overrun = 1'b0;
    logic           ram_we;
    logic [8:0]     ram_waddr;
    logic [15:0]    ram_wdata;
    logic [5:0]     frame;
    logic           engine_rst_n;
    logic           busy;
    logic           overrun;

    int n_checks = 0;
    int n_err    = 0;
    int wcnt;

    always #5 ck = ~ck;

    audio_frame_ctrl #(.CHANNELS(CH), .FRAMES(FR), .RESET_CYCLES(RC)) dut (
        .i_ck(ck), .i_rst(rst), .i_frame_tick(frame_tick), .i_mic_data(mic),
        .i_host_mode(host_mode), .i_host_frame(host_frame), .i_host_we(host_we),
        .i_host_waddr(host_waddr), .i_host_wdata(host_wdata), .i_host_kick(host_kick),
        .i_engine_done(engine_done), .i_clr_overrun(clr_overrun),
        .o_ram_we(ram_we), .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata),
        .o_frame(frame), .o_engine_rst_n(engine_rst_n), .o_busy(busy), .o_overrun(overrun)
    );

    task automatic nxt;
        @(posedge ck);
        #1;
    endtask

    task automatic smp;
        @(negedge ck);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] addr(input int c, input int f);
        logic [2:0] cc;
        logic [5:0] ff;
        cc = c[2:0];
        ff = f[5:0];
        return {cc, ff};
    endfunction

    initial begin
        // Reset state
        repeat (2) nxt();
        smp();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_eng", 32'(engine_rst_n), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_frame", 32'(frame), 0);
        nxt();
        rst = 1'b1;
        nxt();
        nxt();

        // Capture of frame 1: writes T+1..T+8, kick T+9..T+11, run T+12
        for (int n = 0; n < CH; n++) mic[16*n +: 16] = 16'h1000 + 16'(n);
        frame_tick = 1'b1;
        smp();
        chk("t1_idle_busy", 32'(busy), 0);
        nxt();
        frame_tick = 1'b0;
        for (int i = 0; i < CH; i++) begin
            smp();
            chk("t1_we", 32'(ram_we), 1);
            chk("t1_addr", 32'(ram_waddr), 32'(addr(i, 1)));
            chk("t1_data", 32'(ram_wdata), 32'h1000 + 32'(i));
            chk("t1_busy", 32'(busy), 1);
            if (i == 0) chk("t1_frame", 32'(frame), 1);
            nxt();
        end
        for (int k = 0; k < RC; k++) begin
            smp();
            chk("t1_kick_eng", 32'(engine_rst_n), 0);
            chk("t1_kick_we", 32'(ram_we), 0);
            nxt();
        end
        smp();
        chk("t1_run_eng", 32'(engine_rst_n), 1);
        repeat (7) nxt();
        smp();
        chk("t2_run_busy", 32'(busy), 1);
        nxt();
        engine_done = 1'b1;
        nxt();
        engine_done = 1'b0;
        smp();
        chk("t2_idle_busy", 32'(busy), 0);
        chk("t2_idle_eng", 32'(engine_rst_n), 1);

        // Tick during WRITE is dropped and flags overrun
        nxt();
        frame_tick = 1'b1;
        nxt();
        frame_tick = 1'b0;
        wcnt = 0;
        for (int c = 1; c <= 14; c++) begin
            frame_tick = (c == 4);
            smp();
            if (ram_we) wcnt++;
            if (c == 5) chk("t3_ovr_set", 32'(overrun), 1);
            nxt();
        end
        frame_tick = 1'b0;
        chk("t3_write_count", 32'(wcnt), 8);
        clr_overrun = 1'b1;
        nxt();
        clr_overrun = 1'b0;
        smp();
        chk("t3_ovr_clr", 32'(overrun), 0);
        chk("t3_run_busy", 32'(busy), 1);

        // Tick in RUN together with clear: overrun set wins, new capture starts
        frame_tick = 1'b1;
        clr_overrun = 1'b1;
        nxt();
        frame_tick = 1'b0;
        clr_overrun = 1'b0;
        smp();
        chk("t4_ovr_setwins", 32'(overrun), 1);
        chk("t4_we", 32'(ram_we), 1);
        chk("t4_addr", 32'(ram_waddr), 32'(addr(0, 3)));
        nxt();
        nxt();
        nxt();

        // Host takeover at chan 3: writes stop this cycle, IDLE next cycle
        host_mode = 1'b1;
        smp();
        chk("t6_abort_we", 32'(ram_we), 0);
        nxt();
        host_we    = 1'b1;
        host_waddr = 9'h041;
        host_wdata = 16'hBEEF;
        host_frame = 6'd5;
        clr_overrun = 1'b1;
        smp();
        chk("t6_abort_busy", 32'(busy), 0);
        chk("t5_we", 32'(ram_we), 1);
        chk("t5_addr", 32'(ram_waddr), 32'h041);
        chk("t5_data", 32'(ram_wdata), 32'hBEEF);
        chk("t5_frame", 32'(frame), 5);
        nxt();
        host_we = 1'b0;
        clr_overrun = 1'b0;
        frame_tick = 1'b1;
        smp();
        chk("t5_ovr_cleared", 32'(overrun), 0);
        chk("t5_we_off", 32'(ram_we), 0);
        nxt();
        frame_tick = 1'b0;
        smp();
        chk("t5_tick_ignored", 32'(busy), 0);
        chk("t5_tick_no_ovr", 32'(overrun), 0);
        chk("t5_eng_pre", 32'(engine_rst_n), 1);
        host_kick = 1'b1;
        nxt();
        host_kick = 1'b0;
        for (int k = 0; k < RC; k++) begin
            smp();
            chk("t5_kick_eng", 32'(engine_rst_n), 0);
            chk("t5_kick_busy", 32'(busy), 1);
            nxt();
        end
        smp();
        chk("t5_run_eng", 32'(engine_rst_n), 1);
        chk("t5_run_busy", 32'(busy), 1);

        // Async reset in RUN takes effect without a clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("t6_arst_eng", 32'(engine_rst_n), 0);
        chk("t6_arst_busy", 32'(busy), 0);
        host_mode = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t6_post_rst_we", 32'(ram_we), 0);
            nxt();
        end

        // 64 captures: frame counter wraps 63 -> 0
        for (int f = 1; f <= 64; f++) begin
            frame_tick = 1'b1;
            nxt();
            frame_tick = 1'b0;
            smp();
            if (f == 63) chk("t2_addr_63", 32'(ram_waddr), 32'(addr(0, 63)));
            if (f == 64) begin
                chk("t2_addr_wrap", 32'(ram_waddr), 32'(addr(0, 0)));
                chk("t2_frame_wrap", 32'(frame), 0);
            end
            repeat (11) nxt();
            engine_done = 1'b1;
            nxt();
            engine_done = 1'b0;
        end
        smp();
        chk("t2_wrap_no_ovr", 32'(overrun), 0);
        chk("t2_wrap_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
